dmem_arbiter: RTL

- Shares one single-port synchronous data memory between two requesters: port 0 is the core LSU, port 1 is the debug/program-loader master.
- Sits between the LSU memory-mapped data-memory region and the data RAM macro.
- Provides a per-port req/gnt request handshake and an rvalid read response.
- Arbitration is round-robin or fixed priority with a starvation guard.

---
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM.
// Port 0 is the core LSU and port 1 is the debug/loader master. Read responses are routed back by a tagged latency pipeline.
module dmem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [31:0]       m0_wdata_i,
    input  logic [3:0]        m0_be_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [31:0]       m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [31:0]       m1_wdata_i,
    input  logic [3:0]        m1_be_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [31:0]       m1_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    logic              prefer1_q, prefer1_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [RD_LAT-1:0] vld_q, port_q;
    logic [RD_LAT:0]   vld_sh, port_sh;
    logic [31:0]       m0_rdata_q, m1_rdata_q;
    logic              pick1, gnt0, gnt1, rd_push;

    // Raw grants drive state; the outputs are additionally forced low while reset is held.
    always_comb begin
        pick1 = m1_req_i;
        if (m0_req_i && m1_req_i) begin
            if (FIXED_PRIO != 0) begin
                pick1 = (starve_q == LIM);
            end else begin
                pick1 = prefer1_q;
            end
        end
        gnt0    = m0_req_i && !pick1;
        gnt1    = m1_req_i && pick1;
        rd_push = (gnt0 && !m0_we_i) || (gnt1 && !m1_we_i);
    end

    always_comb begin
        prefer1_d = prefer1_q;
        if (gnt0) begin
            prefer1_d = 1'b1;
        end else if (gnt1) begin
            prefer1_d = 1'b0;
        end
        starve_d = starve_q;
        if (!m1_req_i || gnt1) begin
            starve_d = '0;
        end else if (starve_q != LIM) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        m0_gnt_o    = gnt0 && rst_ni;
        m1_gnt_o    = gnt1 && rst_ni;
        mem_en_o    = m0_gnt_o || m1_gnt_o;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (m1_gnt_o) begin
            mem_we_o    = m1_we_i;
            mem_addr_o  = m1_addr_i;
            mem_wdata_o = m1_wdata_i;
            mem_be_o    = m1_be_i;
        end else if (m0_gnt_o) begin
            mem_we_o    = m0_we_i;
            mem_addr_o  = m0_addr_i;
            mem_wdata_o = m0_wdata_i;
            mem_be_o    = m0_be_i;
        end
    end

    // Stage 0 takes the new entry; the top stage lines up with mem_rdata_i.
    assign vld_sh  = {vld_q, rd_push};
    assign port_sh = {port_q, gnt1};

    assign m0_rvalid_o = vld_q[RD_LAT-1] && !port_q[RD_LAT-1];
    assign m1_rvalid_o = vld_q[RD_LAT-1] && port_q[RD_LAT-1];
    assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : m0_rdata_q;
    assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : m1_rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prefer1_q  <= 1'b0;
            starve_q   <= '0;
            vld_q      <= '0;
            port_q     <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            prefer1_q <= prefer1_d;
            starve_q  <= starve_d;
            vld_q     <= vld_sh[RD_LAT-1:0];
            port_q    <= port_sh[RD_LAT-1:0];
            if (m0_rvalid_o) begin
                m0_rdata_q <= mem_rdata_i;
            end
            if (m1_rvalid_o) begin
                m1_rdata_q <= mem_rdata_i;
            end
        end
    end

endmodule
